// File: rtl/pc_redirect_unit_pkg.sv
// Shared types for the fetch next-PC generator: redirect source ids,
// the pending-redirect record and the target alignment helper.
package pc_redirect_unit_pkg;
   localparam int XLEN    = 32;
   localparam int NUM_SRC = 3;
   localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [SRC_W-1:0] {
      SRC_TRAP   = 2'd0,
      SRC_EPC    = 2'd1,
      SRC_BRANCH = 2'd2
   } src_e;

   typedef struct packed {
      logic             valid;
      logic [SRC_W-1:0] src;
      logic [XLEN-1:0]  target;
   } redirect_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] t);
      return {t[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bundle: stall and redirect requests in, PC and flush status out.
interface pc_redirect_unit_if;
   import pc_redirect_unit_pkg::*;

   logic                    stall_i;
   logic [NUM_SRC-1:0]      redir_valid_i;
   logic [NUM_SRC*XLEN-1:0] redir_target_i;
   logic [XLEN-1:0]         pc_o;
   logic [XLEN-1:0]         pc_inc_o;
   logic                    flush_o;
   logic [SRC_W-1:0]        redir_src_o;
   logic                    pending_o;
   logic                    misalign_o;

   modport master (
      output stall_i, redir_valid_i, redir_target_i,
      input  pc_o, pc_inc_o, flush_o, redir_src_o, pending_o, misalign_o
   );

   modport slave (
      input  stall_i, redir_valid_i, redir_target_i,
      output pc_o, pc_inc_o, flush_o, redir_src_o, pending_o, misalign_o
   );
endinterface

// File: rtl/pc_redirect_unit_prio_enc.sv
// Fixed-priority encoder over redirect requests; index 0 wins.
module redir_prio_enc #(
   parameter int N  = 3,
   parameter int W  = 32,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   valid,
   input  logic [N*W-1:0] target,
   output logic           any,
   output logic [IW-1:0]  index,
   output logic [W-1:0]   tgt
);
   // Scan high to low so the lowest valid index is the last (winning) write.
   always_comb begin
      any   = 1'b0;
      index = '0;
      tgt   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (valid[k]) begin
            any   = 1'b1;
            index = IW'(k);
            tgt   = target[k*W +: W];
         end
      end
   end
endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with prioritised redirects, a pending slot that
// holds redirects across stalls, and a restartable flush down-counter.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              PC_INC       = 4,
   parameter int              FLUSH_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_redirect_unit_if.slave bus
);
   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   logic             new_any;
   logic [SRC_W-1:0] new_idx;
   logic [XLEN-1:0]  new_tgt;
   redirect_t        pend_q, win;
   logic [XLEN-1:0]  pc_q;
   logic [SRC_W-1:0] src_q;
   logic             mis_q;
   logic [CW-1:0]    cnt_q;

   redir_prio_enc #(.N(NUM_SRC), .W(XLEN), .IW(SRC_W)) u_enc (
      .valid  (bus.redir_valid_i),
      .target (bus.redir_target_i),
      .any    (new_any),
      .index  (new_idx),
      .tgt    (new_tgt)
   );

   // A fresh request only displaces a held one if it is strictly higher priority.
   always_comb begin
      win = pend_q;
      if (new_any && (!pend_q.valid || new_idx < pend_q.src))
         win = '{valid: 1'b1, src: new_idx, target: new_tgt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         pend_q <= '0;
         src_q  <= '0;
         mis_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         mis_q <= 1'b0;
         if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
         if (bus.stall_i) begin
            pend_q <= win;
         end else if (win.valid) begin
            pc_q   <= align_pc(win.target);
            pend_q <= '0;
            src_q  <= win.src;
            mis_q  <= (win.target[1:0] != 2'b00);
            cnt_q  <= CW'(FLUSH_CYCLES);
         end else begin
            pc_q <= pc_q + XLEN'(PC_INC);
         end
      end
   end

   assign bus.pc_o        = pc_q;
   assign bus.pc_inc_o    = pc_q + XLEN'(PC_INC);
   assign bus.flush_o     = (cnt_q != '0);
   assign bus.redir_src_o = src_q;
   assign bus.pending_o   = pend_q.valid;
   assign bus.misalign_o  = mis_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed scoreboard bench: each stimulus cycle queues the outputs expected
// after the next rising edge; a monitor pops and compares them.
module tb_pc_redirect_unit;
   import pc_redirect_unit_pkg::*;

   typedef struct {
      logic [31:0] pc;
      int          fl;
      int          src;
      int          pend;
      int          mis;
      int          fl3;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   pc_redirect_unit_if bus();
   pc_redirect_unit_if bus3();

   assign bus3.stall_i        = bus.stall_i;
   assign bus3.redir_valid_i  = bus.redir_valid_i;
   assign bus3.redir_target_i = bus.redir_target_i;

   pc_redirect_unit #(.RESET_PC(32'h0), .PC_INC(4), .FLUSH_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   pc_redirect_unit #(.RESET_PC(32'h0), .PC_INC(4), .FLUSH_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rs, input bit st, input logic [2:0] v,
                       input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                       input logic [31:0] pc, input int fl, input int src,
                       input int pend, input int mis, input int fl3);
      exp_t e;
      @(negedge clk);
      rst_n              = rs;
      bus.stall_i        = st;
      bus.redir_valid_i  = v;
      bus.redir_target_i = {t2, t1, t0};
      e = '{pc: pc, fl: fl, src: src, pend: pend, mis: mis, fl3: fl3};
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_o", bus.pc_o, e.pc);
            chk("pc_inc_o", bus.pc_inc_o, e.pc + 32'd4);
            if (e.fl   >= 0) chk("flush_o", 32'(bus.flush_o), 32'(e.fl));
            if (e.src  >= 0) chk("redir_src_o", 32'(bus.redir_src_o), 32'(e.src));
            if (e.pend >= 0) chk("pending_o", 32'(bus.pending_o), 32'(e.pend));
            if (e.mis  >= 0) chk("misalign_o", 32'(bus.misalign_o), 32'(e.mis));
            if (e.fl3  >= 0) chk("flush3_o", 32'(bus3.flush_o), 32'(e.fl3));
         end
      end
   end

   initial begin : stim
      int tr, ep, br, wait_cyc;
      tr = int'(SRC_TRAP);
      ep = int'(SRC_EPC);
      br = int'(SRC_BRANCH);
      bus.stall_i        = 1'b0;
      bus.redir_valid_i  = '0;
      bus.redir_target_i = '0;

      // reset then sequential fetch
      step(0, 0, 3'b000, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0);
      step(1, 0, 3'b000, 0, 0, 0, 32'h4,  0, 0, 0, 0, 0);
      step(1, 0, 3'b000, 0, 0, 0, 32'h8,  0, 0, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0, 32'hC,  0, 0, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0, 32'h10, 0, 0, 0, 0, -1);
      // single redirects and same-cycle priority
      step(1, 0, 3'b010, 0, 32'h100, 0,    32'h100, 1, ep, 0, 0, -1);
      step(1, 0, 3'b100, 0, 0, 32'h40,     32'h40,  1, br, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h44,  0, br, 0, 0, -1);
      step(1, 0, 3'b101, 32'h80, 0, 32'h40, 32'h80, 1, tr, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h84,  0, tr, 0, 0, -1);
      // stall: branch then trap -> trap wins on release
      step(1, 1, 3'b100, 0, 0, 32'h200,    32'h84,  0, tr, 1, 0, -1);
      step(1, 1, 3'b001, 32'h300, 0, 0,    32'h84,  0, tr, 1, 0, -1);
      step(1, 1, 3'b000, 0, 0, 0,          32'h84,  0, tr, 1, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h300, 1, tr, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h304, 0, tr, 0, 0, -1);
      // stall: trap then branch -> branch does not displace
      step(1, 1, 3'b001, 32'h300, 0, 0,    32'h304, 0, tr, 1, 0, -1);
      step(1, 1, 3'b100, 0, 0, 32'h200,    32'h304, 0, tr, 1, 0, -1);
      step(1, 1, 3'b000, 0, 0, 0,          32'h304, 0, tr, 1, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h300, 1, tr, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h304, 0, tr, 0, 0, -1);
      // pending branch beaten by epc on the release cycle
      step(1, 1, 3'b100, 0, 0, 32'h200,    32'h304, 0, tr, 1, 0, -1);
      step(1, 0, 3'b010, 0, 32'h500, 0,    32'h500, 1, ep, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h504, 0, ep, 0, 0, -1);
      // misaligned target and PC wrap
      step(1, 0, 3'b100, 0, 0, 32'h1003,   32'h1000, 1, br, 0, 1, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h1004, 0, br, 0, 0, -1);
      step(1, 0, 3'b010, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, ep, 0, 0, -1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h0,   0, ep, 0, 0, -1);
      // reset while a redirect is pending
      step(1, 1, 3'b100, 0, 0, 32'h200,    32'h0,   0, ep, 1, 0, -1);
      step(0, 1, 3'b000, 0, 0, 0,          32'h0,   0, 0, 0, 0, 0);
      step(1, 0, 3'b000, 0, 0, 0,          32'h4,   0, 0, 0, 0, 0);
      // flush restart on the 3-cycle instance: 5 consecutive high cycles
      step(1, 0, 3'b010, 0, 32'h600, 0,    32'h600, 1, ep, 0, 0, 1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h604, 0, ep, 0, 0, 1);
      step(1, 0, 3'b100, 0, 0, 32'h700,    32'h700, 1, br, 0, 0, 1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h704, 0, br, 0, 0, 1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h708, 0, br, 0, 0, 1);
      step(1, 0, 3'b000, 0, 0, 0,          32'h70C, 0, br, 0, 0, 0);

      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
